// File: rtl/add_share_pkg.sv
// Shared definitions for the add_share_arb block: FSM state encoding,
// default widths and the round-robin winner search.
package add_share_pkg;

    // Sequencer states: accept an operand pair, run the adder, hold the result.
    typedef enum bit [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Default sizing of the block.
    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_W    = 4;

    // Largest supported requester count; the search helper works on this width.
    localparam int unsigned MAX_NREQ = 8;

    // Round-robin search: returns the index of the first set bit of valid at
    // or after ptr, searching upward and wrapping at nreq-1 back to 0. Bits at
    // or above nreq are never considered. When no bit is set the result is
    // ptr; callers qualify the result with an OR-reduction of valid.
    function automatic int unsigned rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input int unsigned         ptr,
        input int unsigned         nreq
    );
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = ptr + k;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end else begin
                idx = idx;
            end
            if ((k < nreq) && !found && valid[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Pointer advance: the slot after idx, wrapping at nreq-1 back to 0.
    function automatic int unsigned rr_next(
        input int unsigned idx,
        input int unsigned nreq
    );
        int unsigned nxt;
        if (idx >= (nreq - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage : add_share_pkg

// File: rtl/add_unit.sv
// Registered adder: sum = a + b at W+1 bits, loaded only when en is high.
module add_unit
    import add_share_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    logic [W:0] sum_q;
    logic [W:0] sum_d;

    // Widen both operands by one bit so the carry out is kept in the sum.
    always_comb begin
        sum_d = {1'b0, a} + {1'b0, b};
    end

    // Sum register: holds its value between enables, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end else begin
            sum_q <= sum_q;
        end
    end

    assign sum = sum_q;

endmodule : add_unit

// File: rtl/add_share_arb.sv
// Round-robin arbiter that shares one registered adder among NREQ requesters.
// One operation takes IDLE (accept) -> CALC (add) -> RESP (hold until taken).
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned W    = DEF_W,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);

    // Sequencer state and registered outputs.
    state_t         state_q;
    logic           rsp_valid_q;
    logic           busy_q;
    logic [IDW-1:0] rsp_id_q;

    // Round-robin pointer and its value after the current winner.
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Operand and id latches filled on the accepting edge.
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [IDW-1:0] pend_id_q;

    // Arbitration results for the current cycle.
    logic           any_valid_s;
    logic [IDW-1:0] winner_s;
    logic [NREQ-1:0] grant_s;
    logic [W-1:0]   sel_a_s;
    logic [W-1:0]   sel_b_s;
    logic           accept_s;

    // Adder interface.
    logic           add_en_s;
    logic [W:0]     sum_s;

    // Winner search from the pointer and the matching operand selection.
    always_comb begin
        any_valid_s = |req_valid;
        winner_s    = IDW'(rr_pick(MAX_NREQ'(req_valid), 32'(ptr_q), NREQ));
        sel_a_s     = req_a[winner_s*W +: W];
        sel_b_s     = req_b[winner_s*W +: W];
    end

    // A request is accepted only in IDLE and never while reset is held, so
    // req_ready is guaranteed low during reset even with valids present.
    always_comb begin
        grant_s  = '0;
        accept_s = 1'b0;
        if ((state_q == S_IDLE) && any_valid_s && !rst) begin
            accept_s          = 1'b1;
            grant_s[winner_s] = 1'b1;
        end else begin
            accept_s = 1'b0;
            grant_s  = '0;
        end
    end

    // Next pointer: the slot after the requester whose result is in flight.
    always_comb begin
        ptr_d = IDW'(rr_next(32'(pend_id_q), NREQ));
    end

    // The adder register updates only in CALC, so rsp_data holds in RESP.
    always_comb begin
        if (state_q == S_CALC) begin
            add_en_s = 1'b1;
        end else begin
            add_en_s = 1'b0;
        end
    end

    // Sequencer: accept in IDLE, add in CALC, hold the result in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            pend_id_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        a_q       <= sel_a_s;
                        b_q       <= sel_b_s;
                        pend_id_q <= winner_s;
                        busy_q    <= 1'b1;
                        state_q   <= S_CALC;
                    end else begin
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                S_CALC: begin
                    rsp_id_q    <= pend_id_q;
                    rsp_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    // rsp_ready is only looked at here, so an early assertion
                    // cannot dequeue a result that does not exist yet.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    add_unit #(
        .W (W)
    ) u_add (
        .clk (clk),
        .rst (rst),
        .en  (add_en_s),
        .a   (a_q),
        .b   (b_q),
        .sum (sum_s)
    );

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = sum_s;
    assign busy      = busy_q;

endmodule : add_share_arb

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb with NREQ=4, W=4.
module tb_add_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W:0]        rsp_data;
    logic              rsp_ready;
    logic              busy;

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_id;
        logic [4:0]  exp_data;
    } vec_t;

    vec_t vecs[8];
    vec_t hv;

    int exp_ids[5];
    int exp_sums[5];

    add_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; starts and ends in IDLE.
    task automatic run_txn(input vec_t v, input int idx);
        @(negedge clk);
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        chk($sformatf("v%0d grant", idx), 32'(req_ready), 32'(v.exp_grant));
        @(negedge clk);
        chk($sformatf("v%0d calc busy", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d calc ready", idx), 32'(req_ready), 32'd0);
        chk($sformatf("v%0d calc rsp_valid", idx), 32'(rsp_valid), 32'd0);
        // Operands change after the accepting edge and must not matter.
        req_a     = ~v.a;
        req_b     = ~v.b;
        req_valid = 4'b0000;
        @(negedge clk);
        chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d rsp_id", idx), 32'(rsp_id), 32'(v.exp_id));
        chk($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(v.exp_data));
        @(negedge clk);
        chk($sformatf("v%0d done rsp_valid", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d done busy", idx), 32'(busy), 32'd0);
    endtask

    // Reset pulse that spans one rising edge; pointer returns to 0.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int last_c;
        bit saw_rsp;

        n_pass  = 0;
        n_total = 0;

        // Vectors run back to back; the pointer carries over between them.
        vecs[0] = '{4'b0100, 16'h0700, 16'h0900, 4'b0100, 2'd2, 5'd16};
        vecs[1] = '{4'b0001, 16'h000F, 16'h000F, 4'b0001, 2'd0, 5'd30};
        vecs[2] = '{4'b1111, 16'h4321, 16'h1234, 4'b0010, 2'd1, 5'd5};
        vecs[3] = '{4'b1011, 16'hC0A2, 16'h5033, 4'b1000, 2'd3, 5'd17};
        vecs[4] = '{4'b1010, 16'hF0E0, 16'h10D0, 4'b0010, 2'd1, 5'd27};
        vecs[5] = '{4'b0001, 16'h9993, 16'h9994, 4'b0001, 2'd0, 5'd7};
        vecs[6] = '{4'b1000, 16'h0555, 16'h1555, 4'b1000, 2'd3, 5'd1};
        vecs[7] = '{4'b1001, 16'h8008, 16'h7008, 4'b0001, 2'd0, 5'd16};

        exp_ids  = '{0, 1, 2, 3, 0};
        exp_sums = '{8, 9, 11, 13, 8};

        // Reset with every requester valid: nothing may be granted.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        rsp_ready = 1'b1;
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", 32'(rsp_data), 32'd0);
        chk("rst rsp_id", 32'(rsp_id), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        rst       = 1'b0;

        // Idle with no requests stays idle.
        @(negedge clk);
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle req_ready", 32'(req_ready), 32'd0);
        chk("idle rsp_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
        end

        // All requesters continuously valid: order 0,1,2,3,0 every 3 cycles.
        do_reset();
        req_valid = 4'b1111;
        req_a     = 16'hC841;
        req_b     = 16'h1357;
        rsp_ready = 1'b1;
        got       = 0;
        last_c    = 0;
        for (int c = 0; c < 40; c++) begin
            if (got < 5) begin
                @(negedge clk);
                if (rsp_valid) begin
                    chk($sformatf("cont id %0d", got), 32'(rsp_id), 32'(exp_ids[got]));
                    chk($sformatf("cont data %0d", got), 32'(rsp_data), 32'(exp_sums[got]));
                    if (got > 0) begin
                        chk($sformatf("cont spacing %0d", got), 32'(c - last_c), 32'd3);
                    end
                    last_c = c;
                    got++;
                end
            end
        end
        chk("cont responses", 32'(got), 32'd5);
        req_valid = 4'b0000;

        // Backpressure: result held for 5 cycles with rsp_ready low.
        do_reset();
        req_valid = 4'b0010;
        req_a     = 16'h0050;
        req_b     = 16'h0060;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp rsp_valid %0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp rsp_data %0d", i), 32'(rsp_data), 32'd11);
            chk($sformatf("bp rsp_id %0d", i), 32'(rsp_id), 32'd1);
            chk($sformatf("bp busy %0d", i), 32'(busy), 32'd1);
            chk($sformatf("bp req_ready %0d", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp release busy", 32'(busy), 32'd0);
        #1;
        chk("bp next grant", 32'(req_ready), 32'b0100);

        // Reset while in CALC: everything clears at once, no response later.
        @(negedge clk);
        chk("pre-rst calc busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async rsp_data", 32'(rsp_data), 32'd0);
        chk("async rsp_id", 32'(rsp_id), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        @(negedge clk);
        rst     = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                saw_rsp = 1'b1;
            end
        end
        chk("no rsp after rst", 32'(saw_rsp), 32'd0);

        // Requester 3 alone, then 0 and 3 together: pointer wrapped to 0.
        hv = '{4'b1000, 16'h6000, 16'h7000, 4'b1000, 2'd3, 5'd13};
        run_txn(hv, 8);
        hv = '{4'b1001, 16'h2001, 16'h3002, 4'b0001, 2'd0, 5'd3};
        run_txn(hv, 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_add_share_arb
